// File: rtl/rv_core_pkg.sv
// Shared core definitions for the register file slice: default widths,
// architectural register indices and the register-file clear FSM states.
package rv_core_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int REG_AW        = $clog2(DEFAULT_NREGS);

  // Architectural register indices with special meaning.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-register write-enable/data select across all write ports: highest port
// index wins on address collisions, and x0 writes are masked when hardwired.
module regfile_wr_arbiter
  import rv_core_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int NREGS   = DEFAULT_NREGS,
  parameter int NWR     = 2,
  parameter int AW      = $clog2(NREGS),
  parameter bit X0_ZERO = 1'b1
) (
  input  logic                  wr_allow,
  input  logic [NWR-1:0]        w_en,
  input  logic [NWR*AW-1:0]     w_sel,
  input  logic [NWR*XLEN-1:0]   w_data,
  output logic [NREGS-1:0]      reg_we,
  output logic [NREGS*XLEN-1:0] reg_wd
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise the tool infers a latch to hold the old value.
  always_comb begin
    reg_we = '0;
    reg_wd = '0;
    for (int r = 0; r < NREGS; r++) begin
      // Ascending port order: a later (higher) port simply overwrites.
      for (int j = 0; j < NWR; j++) begin
        if (wr_allow && w_en[j] && (w_sel[j*AW +: AW] == AW'(r)) &&
            !(X0_ZERO && (r == REG_ZERO))) begin
          reg_we[r]                 = 1'b1;
          reg_wd[r*XLEN +: XLEN]    = w_data[j*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sequenced clear and gated reads.
// Optional same-cycle write-to-read bypass is enabled by REGFILE_BYPASS_EN.
module regfile_mp
  import rv_core_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int NREGS       = DEFAULT_NREGS,
  parameter int NRD         = 2,
  parameter int NWR         = 2,
  parameter int CLR_PER_CYC = 8,
  parameter bit X0_ZERO     = 1'b1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                rst_ready,
  input  logic [NRD*AW-1:0]   r_sel,
  output logic [NRD*XLEN-1:0] r_data,
  input  logic [NWR-1:0]      w_en,
  input  logic [NWR*AW-1:0]   w_sel,
  input  logic [NWR*XLEN-1:0] w_data,
  input  logic [AW-1:0]       dbg_reg_sel,
  output logic [XLEN-1:0]     dbg_reg_data
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              rst_ready_q, rst_ready_d;
  logic              clr_en;
  logic              last_chunk;
  logic              rf_ready;

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  logic [NREGS-1:0]      reg_we;
  logic [NREGS*XLEN-1:0] reg_wd;

  assign rf_ready   = (state_q == RF_READY);
  assign last_chunk = (clr_ptr_q == AW'(NREGS - CLR_PER_CYC));
  assign rst_ready  = rst_ready_q;

  // Clear sequencer: one chunk of CLR_PER_CYC registers per cycle.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rst_ready_d = rst_ready_q;
    clr_en      = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_en    = 1'b1;
        clr_ptr_d = clr_ptr_q + AW'(CLR_PER_CYC);
        if (last_chunk) begin
          state_d     = RF_READY;
          rst_ready_d = 1'b1;
          clr_ptr_d   = '0;
        end
      end
      RF_READY: ;
      default: begin
        state_d     = RF_CLEAR;
        clr_ptr_d   = '0;
        rst_ready_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking (=) is reserved for always_comb.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RF_CLEAR;
      clr_ptr_q   <= '0;
      rst_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rst_ready_q <= rst_ready_d;
    end
  end

  regfile_wr_arbiter #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NWR     (NWR),
    .AW      (AW),
    .X0_ZERO (X0_ZERO)
  ) u_wr_arbiter (
    .wr_allow (rf_ready),
    .w_en     (w_en),
    .w_sel    (w_sel),
    .w_data   (w_data),
    .reg_we   (reg_we),
    .reg_wd   (reg_wd)
  );

  // Storage next-state: nothing changes on a reset edge; clear and
  // writes are mutually exclusive because writes need RF_READY.
  always_comb begin
    regs_d = regs_q;
    if (rst_n) begin
      if (clr_en) begin
        for (int k = 0; k < CLR_PER_CYC; k++) begin
          regs_d[clr_ptr_q + AW'(k)] = '0;
        end
      end
      for (int r = 0; r < NREGS; r++) begin
        if (reg_we[r]) begin
          regs_d[r] = reg_wd[r*XLEN +: XLEN];
        end
      end
    end
  end

  // NOTE: the array has no reset term; zeroing is done by the clear FSM so
  // the storage maps onto plain (non-resettable) flops or RAM.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Read side: the debug port is handled as one extra read port.
  logic [AW-1:0]   rd_addr [NRD+1];
  logic [XLEN-1:0] rd_val  [NRD+1];

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p] = r_sel[p*AW +: AW];
    end
    rd_addr[NRD] = dbg_reg_sel;
  end

  always_comb begin
    for (int p = 0; p <= NRD; p++) begin
      rd_val[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (rf_ready && w_en[j] && (w_sel[j*AW +: AW] == rd_addr[p])) begin
          rd_val[p] = w_data[j*XLEN +: XLEN];
        end
      end
`endif
      if (X0_ZERO && (rd_addr[p] == AW'(REG_ZERO))) begin
        rd_val[p] = '0;
      end
      if (!rf_ready) begin
        rd_val[p] = '0;
      end
    end
  end

  always_comb begin
    r_data = '0;
    for (int p = 0; p < NRD; p++) begin
      r_data[p*XLEN +: XLEN] = rd_val[p];
    end
    dbg_reg_data = rd_val[NRD];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters): directed reset and
// clear sequences, a vector table, and random traffic against an array model.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        rst_ready;
  logic [9:0]  r_sel;
  logic [63:0] r_data;
  logic [1:0]  w_en;
  logic [9:0]  w_sel;
  logic [63:0] w_data;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data;

  int n_pass  = 0;
  int n_total = 0;

  regfile_mp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_ready    (rst_ready),
    .r_sel        (r_sel),
    .r_data       (r_data),
    .w_en         (w_en),
    .w_sel        (w_sel),
    .w_data       (w_data),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: architectural contents plus a clear countdown.
  logic [31:0] model [32];
  bit          model_ready = 1'b0;
  int          clear_left  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (!model_ready || a == 5'd0) return 32'h0;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (w_en[j] && w_sel[j*5 +: 5] == a) v = w_data[j*32 +: 32];
`endif
    return v;
  endfunction

  // Advance one clock edge, updating the model from the inputs seen there.
  task automatic step();
    if (!rst_n) begin
      model_ready = 1'b0;
      clear_left  = 32 / 8;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (!model_ready) begin
      clear_left--;
      if (clear_left == 0) model_ready = 1'b1;
    end else begin
      for (int j = 0; j < 2; j++)
        if (w_en[j] && w_sel[j*5 +: 5] != 5'd0) model[w_sel[j*5 +: 5]] = w_data[j*32 +: 32];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [31:0] d0, input logic [31:0] d1);
    w_en   = en;
    w_sel  = {s1, s0};
    w_data = {d1, d0};
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] ad);
    r_sel       = {a1, a0};
    dbg_reg_sel = ad;
  endtask

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  ws0, ws1;
    logic [31:0] wd0, wd1;
    logic [4:0]  rs0, rs1, rd;
    logic [31:0] e0, e1, ed;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;

    vecs[0] = '{2'b11, 5'd5, 5'd5,  32'h11111111, 32'h22222222, 5'd5,  5'd5, 5'd5,
                32'h22222222, 32'h22222222, 32'h22222222};
    vecs[1] = '{2'b11, 5'd1, 5'd2,  32'hCAFEF00D, 32'h0BADF00D, 5'd1,  5'd2, 5'd0,
                32'hCAFEF00D, 32'h0BADF00D, 32'h00000000};
    vecs[2] = '{2'b11, 5'd0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  5'd0, 5'd1,
                32'h00000000, 32'h00000000, 32'hCAFEF00D};
    vecs[3] = '{2'b11, 5'd1, 5'd31, 32'h00000001, 32'hFFFFFFFF, 5'd31, 5'd1, 5'd5,
                32'hFFFFFFFF, 32'h00000001, 32'h22222222};
    vecs[4] = '{2'b01, 5'd5, 5'd5,  32'h33333333, 32'h44444444, 5'd5,  5'd5, 5'd5,
                32'h33333333, 32'h33333333, 32'h33333333};
    vecs[5] = '{2'b10, 5'd2, 5'd2,  32'h00000009, 32'h00000055, 5'd2,  5'd1, 5'd31,
                32'h00000055, 32'h00000001, 32'hFFFFFFFF};

    // Reset held low for three edges.
    rst_n = 1'b0;
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    set_rd(5'd5, 5'd7, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset rst_ready", {31'h0, rst_ready}, 32'h0);
      check("reset r_data0", r_data[31:0], 32'h0);
      check("reset r_data1", r_data[63:32], 32'h0);
      check("reset dbg", dbg_reg_data, 32'h0);
    end

    // Release; writes to x3 during the clear must be dropped.
    rst_n = 1'b1;
    set_wr(2'b11, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5);
    set_rd(5'd3, 5'd3, 5'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("clear rst_ready low", {31'h0, rst_ready}, 32'h0);
      check("clear r_data0", r_data[31:0], 32'h0);
      check("clear dbg", dbg_reg_data, 32'h0);
      step();
    end
    check("rst_ready after 4 clear cycles", {31'h0, rst_ready}, 32'h1);
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("x3 write during clear dropped", r_data[31:0], 32'h0);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i), 5'(i));
      #1;
      check("cleared reg port0", r_data[31:0], 32'h0);
      check("cleared reg port1", r_data[63:32], 32'h0);
      check("cleared reg dbg", dbg_reg_data, 32'h0);
    end

    // Vector table: write on one edge, read back the next cycle.
    for (int v = 0; v < 6; v++) begin
      set_wr(vecs[v].wen, vecs[v].ws0, vecs[v].ws1, vecs[v].wd0, vecs[v].wd1);
      step();
      set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      set_rd(vecs[v].rs0, vecs[v].rs1, vecs[v].rd);
      #1;
      check($sformatf("vec%0d port0", v), r_data[31:0], vecs[v].e0);
      check($sformatf("vec%0d port1", v), r_data[63:32], vecs[v].e1);
      check($sformatf("vec%0d dbg", v), dbg_reg_data, vecs[v].ed);
    end

    // Reset reasserted after two clear cycles restarts the sequence.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    while (!rst_ready && n < 20) begin
      step();
      n++;
    end
    check("mid-clear restart latency", 32'(n), 32'd4);
    set_rd(5'd5, 5'd1, 5'd31);
    #1;
    check("post restart x5", r_data[31:0], 32'h0);
    check("post restart x1", r_data[63:32], 32'h0);

    // Same-cycle read of a register being written.
    set_wr(2'b01, 5'd7, 5'd0, 32'h12345678, 32'h0);
    set_rd(5'd0, 5'd7, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass same cycle port1", r_data[63:32], 32'h12345678);
    check("bypass same cycle dbg", dbg_reg_data, 32'h12345678);
`else
    check("no bypass same cycle port1", r_data[63:32], 32'h0);
    check("no bypass same cycle dbg", dbg_reg_data, 32'h0);
`endif
    step();
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("x7 next cycle port1", r_data[63:32], 32'h12345678);

    // Random traffic with occasional single-cycle resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = (i % 97 == 50) ? 1'b0 : 1'b1;
      set_wr(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom, $urandom);
      if (i % 4 == 0) set_rd(5'($urandom), 5'($urandom), 5'($urandom));
      else set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
      #1;
      check("rand rst_ready", {31'h0, rst_ready}, {31'h0, model_ready});
      check("rand port0", r_data[31:0], exp_read(r_sel[4:0]));
      check("rand port1", r_data[63:32], exp_read(r_sel[9:5]));
      check("rand dbg", dbg_reg_data, exp_read(dbg_reg_sel));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the RISC-V core, successor to the single-write/dual-read file. Adds N read ports, M write ports with fixed priority, and a sequenced clear FSM that drives a real rst_ready. Sits between decode (reads) and writeback (writes); debug port feeds the on-chip debug mux.

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of read ports
NWR, 2, number of write ports
CLR_PER_CYC, 8, registers zeroed per clear cycle (must divide NREGS)
X0_ZERO, 1, 1 = register 0 hardwired to zero

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rst_ready  out  1  high once clear sequence has finished
r_sel  in  NRD*AW  read addresses, port k at [k*AW +: AW], AW = clog2(NREGS)
r_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
w_en  in  NWR  per-port write enable
w_sel  in  NWR*AW  write addresses
w_data  in  NWR*XLEN  write data
dbg_reg_sel  in  AW  debug read address
dbg_reg_data  out  XLEN  debug read data

Behaviour:
- Reset is rst_n, synchronous, active-low; clock clk.
- FSM states: CLEAR, READY. rst_n low at a clock edge -> state CLEAR, clr_ptr 0, rst_ready 0; no register written that edge.
- CLEAR with rst_n high: zero registers clr_ptr .. clr_ptr+CLR_PER_CYC-1, clr_ptr += CLR_PER_CYC. On the edge writing the last chunk -> READY, rst_ready 1 from the next cycle. Clear takes exactly NREGS/CLR_PER_CYC cycles after rst_n deasserts (defaults: 4).
- rst_n reasserted mid-clear: restart; clr_ptr 0, rst_ready 0.
- rst_ready reset value 0; stays 1 in READY until next rst_n low.
- While not READY: all w_en ignored; r_data and dbg_reg_data forced to 0.
- Reads are asynchronous (combinational from r_sel/dbg_reg_sel); write visible on reads the cycle after the edge.
- Writes in READY: port j writes w_data[j] to w_sel[j] when w_en[j]. Several ports same address same cycle: highest port index wins.
- X0_ZERO=1: writes to address 0 dropped; reads of address 0 return 0 on all read and debug ports. X0_ZERO=0: register 0 ordinary.
- Same-cycle read/write of one address returns the old value (no bypass) unless the optional feature is enabled.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: each read port and debug port compares its address with every active write port in READY; on match returns that w_data (highest matching port index wins), same cycle. Address 0 with X0_ZERO=1 still returns 0. Gating while not READY still applies.
- Undefined: no bypass logic; reads return stored value only.

Decomposition:
- Shared package rv_core_pkg: XLEN default, REG_AW, register-index constants (REG_ZERO), FSM state enum (RF_CLEAR, RF_READY).
- One sub-module natural: regfile_wr_arbiter (combinational per-register write-enable/data select with port priority and x0 masking); bypass mux stays inline.

Test Plan:
- Reset: rst_n low 3 cycles then high -> rst_ready 0 for exactly 4 cycles, then 1; every r_data 0 throughout; all 32 regs read 0 after.
- Mid-clear reset: deassert, after 2 clear cycles assert rst_n 1 cycle, deassert -> rst_ready rises exactly 4 cycles after final deassert.
- Priority: READY, port0 writes x5=0x11111111 and port1 writes x5=0x22222222 same cycle -> next cycle x5 reads 0x22222222 on both read ports and debug port.
- x0: write x0=0xDEADBEEF on both ports -> r_sel=0 returns 0x00000000; x1 unaffected.
- Write during clear: w_en=2'b11 to x3=0xA5A5A5A5 during CLEAR -> x3 reads 0 after rst_ready.
- Bypass (REGFILE_BYPASS_EN defined): write x7=0x12345678 while r_sel port1=7 -> r_data port1 = 0x12345678 same cycle; without macro -> 0 same cycle, 0x12345678 next cycle.
